// File: rtl/regfile_param.sv
// Multi-entry register file: two read ports, one write port, reserve/write pending
// scoreboard with a population counter, optional registered reads and hardwired-zero entry 0.
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int RD_REG   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_pend0,
  output logic              rd_pend1,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_err,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              err;

  logic wr_ok;
  logic rsv_ok;
  logic rsv_same;
  logic rsv_acc;
  logic rsv_bad;
  logic wr_clr;

  // Writes and reserves to entry 0 vanish entirely when it is hardwired to zero.
  assign wr_ok    = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
  assign rsv_ok   = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  assign rsv_same = wr_ok && (wr_addr == rsv_addr);
  assign rsv_acc  = rsv_ok && (!pend[rsv_addr] || rsv_same);
  assign rsv_bad  = rsv_ok && pend[rsv_addr] && !rsv_same;
  assign wr_clr   = wr_ok && pend[wr_addr];

  always_comb begin
    pend_nxt = pend;
    if (wr_ok)   pend_nxt[wr_addr]  = 1'b0;
    if (rsv_acc) pend_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (rsv_acc && !wr_clr)      cnt_nxt = cnt + CNT_ONE;
    else if (!rsv_acc && wr_clr) cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
      err  <= rsv_bad;
    end
  end

  assign rsv_err  = err;
  assign pend_cnt = cnt;

  logic [DATA_W-1:0] c_data0;
  logic [DATA_W-1:0] c_data1;
  logic              c_pend0;
  logic              c_pend1;

  // Bypass shows the write but not a same-cycle reserve.
  always_comb begin
    c_data0 = mem[rd_addr0];
    c_pend0 = pend[rd_addr0];
    if (wr_ok && wr_addr == rd_addr0) begin
      c_data0 = wr_data;
      c_pend0 = 1'b0;
    end
    if (ZERO_REG != 0 && rd_addr0 == '0) begin
      c_data0 = '0;
      c_pend0 = 1'b0;
    end
  end

  always_comb begin
    c_data1 = mem[rd_addr1];
    c_pend1 = pend[rd_addr1];
    if (wr_ok && wr_addr == rd_addr1) begin
      c_data1 = wr_data;
      c_pend1 = 1'b0;
    end
    if (ZERO_REG != 0 && rd_addr1 == '0) begin
      c_data1 = '0;
      c_pend1 = 1'b0;
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] q_data0;
      logic [DATA_W-1:0] q_data1;
      logic              q_pend0;
      logic              q_pend1;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q_data0 <= '0;
          q_data1 <= '0;
          q_pend0 <= 1'b0;
          q_pend1 <= 1'b0;
        end else begin
          q_data0 <= c_data0;
          q_data1 <= c_data1;
          q_pend0 <= c_pend0;
          q_pend1 <= c_pend1;
        end
      end

      assign rd_data0 = q_data0;
      assign rd_data1 = q_data1;
      assign rd_pend0 = q_pend0;
      assign rd_pend1 = q_pend1;
    end else begin : g_rd_comb
      assign rd_data0 = c_data0;
      assign rd_data1 = c_data1;
      assign rd_pend0 = c_pend0;
      assign rd_pend1 = c_pend1;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: two configurations (combinational read / registered read with
// hardwired zero) share one stimulus stream and are checked against a behavioural model.
module tb_regfile_param;

  logic       clk;
  logic       rst_n;
  logic [2:0] rd_addr0;
  logic [2:0] rd_addr1;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rsv_en;
  logic [2:0] rsv_addr;

  logic [7:0] a_d0, a_d1, b_d0, b_d1;
  logic       a_p0, a_p1, b_p0, b_p1;
  logic       a_err, b_err;
  logic [3:0] a_cnt, b_cnt;

  regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .RD_REG(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(a_d0), .rd_data1(a_d1), .rd_pend0(a_p0), .rd_pend1(a_p1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_err(a_err), .pend_cnt(a_cnt)
  );

  regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .RD_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(b_d0), .rd_data1(b_d1), .rd_pend0(b_p0), .rd_pend1(b_p1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_err(b_err), .pend_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       p0;
    logic       p1;
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference state: plain arrays indexed by configuration (0 = A, 1 = B).
  logic [7:0] mm [2][8];
  logic       mp [2][8];
  logic       me [2];
  exp_t       mr [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic comb_read(input int k, input bit zero, input logic [2:0] a,
                           output logic [7:0] d, output logic p);
    if (zero && a == 3'd0) begin
      d = 8'h00; p = 1'b0;
    end else if (wr_en && !(zero && wr_addr == 3'd0) && wr_addr == a) begin
      d = wr_data; p = 1'b0;
    end else begin
      d = mm[k][a]; p = mp[k][a];
    end
  endtask

  // Expected outputs for the current cycle, then advance the model across the next edge.
  task automatic model_cycle(input int k, input bit zero, input bit rdreg, output exp_t e);
    exp_t c;
    int   pc;
    bit   wv;
    bit   rv;
    c = '0;
    comb_read(k, zero, rd_addr0, c.d0, c.p0);
    comb_read(k, zero, rd_addr1, c.d1, c.p1);
    pc = 0;
    for (int i = 0; i < 8; i++) pc += int'(mp[k][i]);
    e     = rdreg ? mr[k] : c;
    e.cnt = 4'(pc);
    e.err = me[k];
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mm[k][i] = 8'h00;
        mp[k][i] = 1'b0;
      end
      mr[k] = '0;
      me[k] = 1'b0;
    end else begin
      wv = wr_en  && !(zero && wr_addr  == 3'd0);
      rv = rsv_en && !(zero && rsv_addr == 3'd0);
      mr[k] = c;
      if (wv) begin
        mm[k][wr_addr] = wr_data;
        mp[k][wr_addr] = 1'b0;
      end
      me[k] = rv && mp[k][rsv_addr];
      if (rv) mp[k][rsv_addr] = 1'b1;
    end
  endtask

  task automatic step(input bit rn, input bit we, input logic [2:0] wa, input logic [7:0] wd,
                      input bit re, input logic [2:0] ra, input logic [2:0] a0, input logic [2:0] a1);
    exp_t ea;
    exp_t eb;
    rst_n    = rn;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra;
    rd_addr0 = a0;
    rd_addr1 = a1;
    model_cycle(0, 1'b0, 1'b0, ea);
    model_cycle(1, 1'b1, 1'b1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] a0, input logic [2:0] a1);
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, a0, a1);
  endtask

  // Monitor: every mid-cycle, compare what each DUT presents with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_rd_data0", int'(a_d0),  int'(e.d0));
        check("a_rd_data1", int'(a_d1),  int'(e.d1));
        check("a_rd_pend0", int'(a_p0),  int'(e.p0));
        check("a_rd_pend1", int'(a_p1),  int'(e.p1));
        check("a_pend_cnt", int'(a_cnt), int'(e.cnt));
        check("a_rsv_err",  int'(a_err), int'(e.err));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_rd_data0", int'(b_d0),  int'(e.d0));
        check("b_rd_data1", int'(b_d1),  int'(e.d1));
        check("b_rd_pend0", int'(b_p0),  int'(e.p0));
        check("b_rd_pend1", int'(b_p1),  int'(e.p1));
        check("b_pend_cnt", int'(b_cnt), int'(e.cnt));
        check("b_rsv_err",  int'(b_err), int'(e.err));
      end
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    rsv_en = 1'b0; rsv_addr = 3'd0; rd_addr0 = 3'd0; rd_addr1 = 3'd0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        mm[k][i] = 8'h00;
        mp[k][i] = 1'b0;
      end
      mr[k] = '0;
      me[k] = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;

    idle(3'd0, 3'd7);
    step(1, 1, 3'd3, 8'hA5, 0, 3'd0, 3'd3, 3'd5);
    idle(3'd3, 3'd5);
    step(1, 0, 3'd0, 8'h00, 1, 3'd2, 3'd2, 3'd2);
    step(1, 0, 3'd0, 8'h00, 1, 3'd2, 3'd2, 3'd2);
    step(1, 1, 3'd2, 8'h3C, 0, 3'd0, 3'd2, 3'd2);
    idle(3'd2, 3'd2);
    step(1, 0, 3'd0, 8'h00, 1, 3'd4, 3'd4, 3'd4);
    step(1, 1, 3'd4, 8'h11, 1, 3'd4, 3'd4, 3'd4);
    idle(3'd4, 3'd4);
    idle(3'd4, 3'd4);
    for (int i = 0; i < 8; i++) step(1, 0, 3'd0, 8'h00, 1, 3'(i), 3'(i), 3'd0);
    idle(3'd7, 3'd6);
    for (int i = 0; i < 8; i++) step(1, 1, 3'(i), 8'(i * 17 + 3), 0, 3'd0, 3'(i), 3'd7);
    idle(3'd7, 3'd1);
    step(1, 1, 3'd1, 8'h7E, 0, 3'd0, 3'd0, 3'd1);
    idle(3'd0, 3'd1);
    idle(3'd1, 3'd1);
    step(1, 1, 3'd0, 8'hFF, 1, 3'd0, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    idle(3'd0, 3'd0);
    step(1, 1, 3'd6, 8'h55, 1, 3'd7, 3'd6, 3'd7);
    step(1, 0, 3'd0, 8'h00, 1, 3'd3, 3'd6, 3'd7);
    step(0, 1, 3'd5, 8'h66, 1, 3'd5, 3'd6, 3'd7);
    idle(3'd6, 3'd5);
    idle(3'd7, 3'd3);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 60) != 0),
           ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 1) == 0), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    idle(3'd0, 3'd0);

    budget = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
